// File: rtl/cpu_stall_harness_if.sv
// Bus between the stall harness and whatever drives/observes it.
// The master drives the control inputs and the monitored PC; the slave is the harness.
interface cpu_stall_harness_if #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
);
    logic                 en;
    logic [1:0]           mode;
    logic [7:0]           period;
    logic [7:0]           burst_len;
    logic [PC_WIDTH-1:0]  break_pc;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 stallreq_cpu;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [PC_WIDTH-1:0]  pc_last;

    modport master (
        output en, mode, period, burst_len, break_pc, pc_in,
        input  stallreq_cpu, halted, cycle_count, stall_count, pc_last
    );

    modport slave (
        input  en, mode, period, burst_len, break_pc, pc_in,
        output stallreq_cpu, halted, cycle_count, stall_count, pc_last
    );
endinterface

// File: rtl/cpu_stall_harness.sv
// Stall-request generator (none/periodic/random/breakpoint) plus PC halt monitor
// and saturating run/stall cycle counters for the CPU test build.
module cpu_stall_harness #(
    parameter int          PC_WIDTH    = 16,
    parameter int          CNT_WIDTH   = 32,
    parameter int          HALT_CYCLES = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    cpu_stall_harness_if.slave bus
);
    localparam int SC_W = $clog2(HALT_CYCLES + 1);

    logic [15:0]          r_lfsr;
    logic [1:0]           r_mode_q;
    logic [7:0]           r_phase;
    logic [7:0]           r_bcnt;
    logic                 r_armed;
    logic [SC_W-1:0]      r_sc;
    logic                 r_stall;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_cyc;
    logic [CNT_WIDTH-1:0] r_scnt;
    logic [PC_WIDTH-1:0]  r_pc_last;

    logic                 w_active;
    logic                 w_mode_chg;
    logic                 w_lfsr_fb;
    logic                 w_pc_eq;
    logic                 w_bp_match;
    logic                 w_hit;
    logic                 w_phase_wrap;
    logic [SC_W-1:0]      w_sc_next;
    logic                 w_stall_nxt;
    logic [7:0]           w_phase_nxt;
    logic [7:0]           w_bcnt_nxt;
    logic                 w_armed_nxt;

    assign w_active     = bus.en && !r_halted;
    assign w_mode_chg   = bus.mode != r_mode_q;
    assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_pc_eq      = bus.pc_in == r_pc_last;
    assign w_bp_match   = bus.pc_in == bus.break_pc;
    assign w_hit        = r_armed && w_bp_match && (bus.burst_len != 8'd0);
    assign w_phase_wrap = ({1'b0, r_phase} + 9'd1) >= {1'b0, bus.period};
    // A stalled CPU legitimately repeats its PC, so stalled cycles neither count nor clear.
    assign w_sc_next    = r_stall ? r_sc : (w_pc_eq ? r_sc + 1'b1 : '0);

    always_comb begin
        w_stall_nxt = 1'b0;
        w_phase_nxt = r_phase;
        w_bcnt_nxt  = r_bcnt;
        w_armed_nxt = r_armed;
        if (w_mode_chg) begin
            w_phase_nxt = 8'd0;
            w_bcnt_nxt  = 8'd0;
            w_armed_nxt = 1'b1;
        end else begin
            case (bus.mode)
                2'b01: begin
                    w_stall_nxt = (bus.period != 8'd0) && (r_phase < bus.burst_len);
                    w_phase_nxt = w_phase_wrap ? 8'd0 : r_phase + 8'd1;
                end
                2'b10: w_stall_nxt = (r_lfsr[1:0] == 2'b00);
                2'b11: begin
                    if (r_bcnt != 8'd0) begin
                        w_stall_nxt = 1'b1;
                        w_bcnt_nxt  = r_bcnt - 8'd1;
                    end else if (w_hit) begin
                        w_bcnt_nxt  = bus.burst_len;
                        w_armed_nxt = 1'b0;
                    end else if (!w_bp_match) begin
                        w_armed_nxt = 1'b1;
                    end
                end
                default: w_stall_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr    <= LFSR_SEED;
            r_mode_q  <= 2'b00;
            r_phase   <= 8'd0;
            r_bcnt    <= 8'd0;
            r_armed   <= 1'b1;
            r_sc      <= '0;
            r_stall   <= 1'b0;
            r_halted  <= 1'b0;
            r_cyc     <= '0;
            r_scnt    <= '0;
            r_pc_last <= '0;
        end else if (w_active) begin
            r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
            r_mode_q  <= bus.mode;
            r_phase   <= w_phase_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_armed   <= w_armed_nxt;
            r_sc      <= w_sc_next;
            r_stall   <= w_stall_nxt;
            r_halted  <= r_halted | (w_sc_next == SC_W'(HALT_CYCLES));
            r_pc_last <= bus.pc_in;
            if (!(&r_cyc))
                r_cyc <= r_cyc + 1'b1;
            if (r_stall && !(&r_scnt))
                r_scnt <= r_scnt + 1'b1;
        end else begin
            r_stall <= 1'b0;
        end
    end

    assign bus.stallreq_cpu = r_stall;
    assign bus.halted       = r_halted;
    assign bus.cycle_count  = r_cyc;
    assign bus.stall_count  = r_scnt;
    assign bus.pc_last      = r_pc_last;
endmodule

// File: tb/tb_cpu_stall_harness.sv
// Self-checking bench: breakpoint vector table, hand-written periodic/halt/random-reset
// sequences, and randomized mode/enable segments against a behavioural model.
module tb_cpu_stall_harness;
    localparam int PW   = 16;
    localparam int CW   = 10;
    localparam int HC   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_stall_harness_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus();

    cpu_stall_harness #(
        .PC_WIDTH(PW), .CNT_WIDTH(CW), .HALT_CYCLES(HC), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  burst;
        logic [15:0] pc;
        logic        exp_stall;
    } bp_vec_t;

    int errors = 0;
    int checks = 0;

    logic [15:0] seq [0:4095];

    // behavioural model state
    logic        m_stall, m_halt;
    logic [1:0]  m_mq;
    logic [15:0] m_pclast;
    int          m_cyc, m_scnt, m_run, m_k, m_idx;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_stall = 0; m_halt = 0; m_mq = 0; m_pclast = 0;
        m_cyc = 0; m_scnt = 0; m_run = 0; m_k = 0; m_idx = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Rule-level model of one clock edge, given the inputs currently driven.
    task automatic model_edge();
        logic [15:0] pre;
        if (!(bus.en && !m_halt)) begin
            m_stall = 0;
            return;
        end
        if (m_cyc != MAXC) m_cyc++;
        if (m_stall && m_scnt != MAXC) m_scnt++;
        if (!m_stall) begin
            m_run = (bus.pc_in == m_pclast) ? m_run + 1 : 0;
            if (m_run == HC) m_halt = 1;
        end
        pre   = seq[m_idx % 4096];
        m_idx = m_idx + 1;
        if (bus.mode != m_mq) begin
            m_k = 0;
            m_stall = 0;
        end else begin
            m_k++;
            case (bus.mode)
                2'd1:    m_stall = (bus.period != 0) && (((m_k - 1) % int'(bus.period)) < int'(bus.burst_len));
                2'd2:    m_stall = (pre[1:0] == 2'b00);
                default: m_stall = 0;
            endcase
        end
        m_mq     = bus.mode;
        m_pclast = bus.pc_in;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bp_vec_t bp[27];
        logic [15:0] pcv;
        int k, curm, nm, len;

        seq[0] = 16'hACE1;
        for (int i = 1; i < 4096; i++)
            seq[i] = {seq[i-1][0] ^ seq[i-1][2] ^ seq[i-1][3] ^ seq[i-1][5], seq[i-1][15:1]};

        bp = '{
            '{2'd3, 8'd3, 16'h003D, 1'b0}, '{2'd3, 8'd3, 16'h003E, 1'b0}, '{2'd3, 8'd3, 16'h003F, 1'b0},
            '{2'd3, 8'd3, 16'h0040, 1'b0}, '{2'd3, 8'd3, 16'h0040, 1'b1}, '{2'd3, 8'd3, 16'h0040, 1'b1},
            '{2'd3, 8'd3, 16'h0040, 1'b1}, '{2'd3, 8'd3, 16'h0040, 1'b0}, '{2'd3, 8'd3, 16'h0040, 1'b0},
            '{2'd3, 8'd3, 16'h0041, 1'b0}, '{2'd3, 8'd3, 16'h0040, 1'b0}, '{2'd3, 8'd3, 16'h0041, 1'b1},
            '{2'd3, 8'd3, 16'h0041, 1'b1}, '{2'd3, 8'd3, 16'h0041, 1'b1}, '{2'd3, 8'd3, 16'h0041, 1'b0},
            '{2'd3, 8'd3, 16'h0042, 1'b0}, '{2'd3, 8'd0, 16'h0040, 1'b0}, '{2'd3, 8'd2, 16'h0040, 1'b0},
            '{2'd3, 8'd2, 16'h0040, 1'b1}, '{2'd3, 8'd2, 16'h0040, 1'b1}, '{2'd3, 8'd2, 16'h0040, 1'b0},
            '{2'd0, 8'd2, 16'h0041, 1'b0}, '{2'd3, 8'd2, 16'h0040, 1'b0}, '{2'd3, 8'd2, 16'h0040, 1'b0},
            '{2'd3, 8'd2, 16'h0040, 1'b1}, '{2'd3, 8'd2, 16'h0040, 1'b1}, '{2'd3, 8'd2, 16'h0041, 1'b0}
        };

        // Reset with arbitrary active inputs
        bus.en = 1; bus.mode = 2'b01; bus.period = 3; bus.burst_len = 2;
        bus.break_pc = 16'h1234; bus.pc_in = 16'h1234; rst = 1;
        tick(); tick();
        chk("reset_stall", bus.stallreq_cpu, 0);
        chk("reset_halted", bus.halted, 0);
        chk("reset_cycle_count", bus.cycle_count, 0);
        chk("reset_stall_count", bus.stall_count, 0);
        chk("reset_pc_last", bus.pc_last, 0);

        // Periodic: period 4, burst 1; first edge is the mode change from reset mode 0
        rst = 0; bus.mode = 2'b01; bus.period = 4; bus.burst_len = 1;
        for (int i = 0; i < 100; i++) begin
            bus.pc_in = 16'(i); tick();
            chk("periodic_stall", bus.stallreq_cpu, (i >= 1) && ((i - 1) % 4 == 0));
        end
        chk("periodic_stall_count", bus.stall_count, 25);
        chk("periodic_cycle_count", bus.cycle_count, 100);
        for (int i = 100; i < 1100; i++) begin
            bus.pc_in = 16'(i); tick();
        end
        chk("cycle_count_saturated", bus.cycle_count, MAXC);
        chk("periodic_stall_count_1100", bus.stall_count, 275);
        bus.burst_len = 4;
        for (int i = 1100; i < 1900; i++) begin
            bus.pc_in = 16'(i); tick();
        end
        chk("continuous_stall", bus.stallreq_cpu, 1);
        chk("stall_count_saturated", bus.stall_count, MAXC);
        bus.en = 0; bus.pc_in = 16'h7777; tick();
        chk("disabled_stall_low", bus.stallreq_cpu, 0);
        chk("disabled_pc_last_hold", bus.pc_last, 1899);
        chk("disabled_cycle_hold", bus.cycle_count, MAXC);

        // Breakpoint vector table
        bus.en = 1; bus.break_pc = 16'h0040;
        do_reset();
        foreach (bp[i]) begin
            bus.mode = bp[i].mode; bus.burst_len = bp[i].burst; bus.pc_in = bp[i].pc;
            tick();
            chk($sformatf("bp_stall[%0d]", i), bus.stallreq_cpu, bp[i].exp_stall);
        end
        chk("bp_halted", bus.halted, 0);
        chk("bp_stall_count", bus.stall_count, 10);

        // Halt: PC parked at 0x100 from cycle 10
        bus.mode = 2'b00;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            bus.pc_in = (i < 10) ? 16'(i) : 16'h0100; tick();
            chk($sformatf("halt[%0d]", i), bus.halted, i >= 18);
        end
        chk("halt_cycle_frozen", bus.cycle_count, 19);
        chk("halt_stall_low", bus.stallreq_cpu, 0);

        // Halt with periodic stalls: two stalled cycles in the window delay it by two
        bus.mode = 2'b01; bus.period = 4; bus.burst_len = 1;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            bus.pc_in = (i < 10) ? 16'(i) : 16'h0100; tick();
            chk($sformatf("halt_stall[%0d]", i), bus.halted, i >= 20);
            if (i == 21) chk("halt_stall_drop", bus.stallreq_cpu, 0);
        end
        chk("halt_stall_cycle_frozen", bus.cycle_count, 21);

        // Random mode from reset, then reset mid-burst and replay
        for (int pass = 0; pass < 2; pass++) begin
            bus.mode = 2'b10; bus.en = 1;
            do_reset();
            for (int i = 0; i < 64; i++) begin
                bus.pc_in = 16'(i); tick();
                chk("random_stall", bus.stallreq_cpu, (i >= 1) && (seq[i][1:0] == 2'b00));
            end
            if (pass == 0) begin
                k = 64;
                while (seq[k-1][1:0] != 2'b00 && k < 200) begin
                    bus.pc_in = 16'(k); tick();
                    chk("random_stall_tail", bus.stallreq_cpu, seq[k][1:0] == 2'b00);
                    k++;
                end
                chk("random_prereset_stall", bus.stallreq_cpu, 1);
                rst = 1; bus.mode = 2'b01; tick(); rst = 0;
                chk("midburst_reset_stall", bus.stallreq_cpu, 0);
                chk("midburst_reset_cycles", bus.cycle_count, 0);
                chk("midburst_reset_pc_last", bus.pc_last, 0);
            end
        end

        // Randomized mode/enable segments against the model
        do_reset();
        curm = 0; pcv = 16'h0;
        for (int seg = 0; seg < 30; seg++) begin
            nm = $urandom_range(0, 2);
            if (nm == curm) nm = (nm + 1) % 3;
            curm = nm;
            bus.mode = 2'(nm);
            bus.period = 8'($urandom_range(0, 9));
            bus.burst_len = 8'($urandom_range(0, 10));
            len = $urandom_range(20, 60);
            for (int c = 0; c < len; c++) begin
                bus.en = ($urandom % 5) != 0;
                if (($urandom % 4) != 0) pcv = 16'($urandom);
                bus.pc_in = pcv;
                model_edge();
                tick();
                chk("rnd_stall", bus.stallreq_cpu, m_stall);
                chk("rnd_halted", bus.halted, m_halt);
                chk("rnd_cycle_count", bus.cycle_count, m_cyc);
                chk("rnd_stall_count", bus.stall_count, m_scnt);
                chk("rnd_pc_last", bus.pc_last, m_pclast);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_stall_harness.md
# cpu_stall_harness

Synthesizable stimulus and monitor block that sits beside the CPU core in the test build. It generates the CPU's `stallreq_cpu` input according to a runtime-selectable mode and watches the CPU's program counter. It flags a halt when the PC stops advancing, and counts run and stall cycles. It replaces fixed, hand-driven stall stimulus with a parametrised, repeatable generator that can run on bench or FPGA.

## Interface
- `PC_WIDTH`, 16: width of the monitored PC.
- `CNT_WIDTH`, 32: width of the cycle and stall counters.
- `HALT_CYCLES`, 8: consecutive unstalled cycles with unchanged PC that declare a halt (>= 2).
- `LFSR_SEED`, 16'hACE1: reset value of the random-mode LFSR (must be nonzero).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: run enable; when 0, all state is frozen and `stallreq_cpu` is driven 0 on the next edge.
- `mode` in 2: 00 none, 01 periodic, 10 random, 11 breakpoint.
- `period` in 8: periodic-mode period in cycles; 0 means never stall.
- `burst_len` in 8: stall length per period or per breakpoint hit.
- `break_pc` in PC_WIDTH: breakpoint address.
- `pc_in` in PC_WIDTH: CPU program counter (the core's `pc_test`).
- `stallreq_cpu` out 1: registered stall request to the CPU.
- `halted` out 1: sticky halt flag.
- `cycle_count` out CNT_WIDTH: cycles with `en`=1 and `halted`=0; saturates at all-ones.
- `stall_count` out CNT_WIDTH: cycles with `stallreq_cpu`=1; saturates.
- `pc_last` out PC_WIDTH: PC sampled on the previous enabled edge.

## Operation
- **Reset values:** all outputs 0, all internal counters 0, LFSR=`LFSR_SEED`, breakpoint armed=1, `mode_q`=0.
- **Global gating:**
  - State advances only on edges where `en`=1 and `halted`=0.
  - Otherwise counters, LFSR, and `pc_last` hold, and `stallreq_cpu` is driven 0.
- **LFSR:**
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Advances on every enabled edge in every mode, so the sequence is deterministic from reset.
- **Mode change:**
  - `mode_q` registers `mode`.
  - When `mode` != `mode_q`, the phase counter and burst counter clear to 0 and the breakpoint re-arms on that edge.
  - `stallreq_cpu` is 0 on that edge.
- **Mode 00 (none):** `stallreq_cpu` is 0.
- **Mode 01 (periodic):**
  - Phase counter `p` counts 0..`period`-1 and wraps.
  - `stallreq_cpu` <= (`period` != 0) && (`p` < `burst_len`).
  - `burst_len` >= `period` gives a continuous stall.
- **Mode 10 (random):** `stallreq_cpu` <= (`lfsr[1:0]` == 2'b00), using the pre-advance LFSR value (about a 25% duty cycle).
- **Mode 11 (breakpoint):**
  - A hit occurs when armed && `pc_in` == `break_pc` && `burst_len` != 0. On a hit, `bcnt` <= `burst_len` and armed <= 0.
  - `stallreq_cpu` is 1 while `bcnt` != 0, and `bcnt` decrements each edge.
  - Re-arms when `bcnt` == 0 and `pc_in` != `break_pc`.
  - A hit with `burst_len`=0 is ignored and does not disarm.
- **Halt detection:**
  - `pc_last` <= `pc_in` on every enabled edge.
  - Same-counter `sc`:
    - holds when `stallreq_cpu`=1;
    - otherwise increments if `pc_in` == `pc_last`, and clears if they differ.
  - `halted` <= 1 on the edge at which `sc` would reach `HALT_CYCLES`.
  - `halted` stays set until `rst`.
- **Counters:**
  - `stall_count` increments on an enabled edge when the current `stallreq_cpu`=1.
  - Both counters saturate; they never wrap.

## Timing
- `stallreq_cpu` is registered and reflects conditions sampled one edge earlier. Breakpoint hit at edge N gives `stallreq_cpu`=1 after edge N+1 for exactly `burst_len` cycles.
- **Periodic mode after `en` rises:**
  - The first stall is visible after the first enabled edge, when `p`=0.
  - The pattern repeats every `period` cycles.
- **Halt timing:**
  - `halted` rises one edge after the last qualifying comparison.
  - On the edge `halted` rises, `cycle_count` still increments; it freezes from the next edge.
  - `stallreq_cpu` drops to 0 on the edge after `halted` rises.
- **Reset dominance:** `rst` asserted mid-burst or mid-period clears everything on that edge, and `stallreq_cpu`=0 next cycle. Reset dominates `en` and `mode`.
- **Simultaneous events:** a mode change and a breakpoint hit on the same edge means the mode change wins and no hit is taken.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with any inputs -> all outputs 0; `pc_last`=0.
- **Periodic:** mode 01, `period`=4, `burst_len`=1, PC incrementing -> `stallreq_cpu` pattern 1,0,0,0 repeating; `stall_count`=25 after 100 enabled cycles.
- **Breakpoint:** mode 11, `break_pc`=16'h0040, `burst_len`=3, PC steps by 1 and holds while stalled -> exactly 3 stall cycles starting 2 edges after `pc_in`=0x0040. No second hit until PC leaves and returns to 0x0040.
- **Halt:** mode 00, `pc_in` held at 16'h0100 from cycle 10 -> `halted`=1 after `HALT_CYCLES`(8) equal samples. After that, `cycle_count` is frozen and `stallreq_cpu`=0.
- **Halt with stalls:** same as the halt test but with periodic stalls active -> stalled cycles do not advance `sc`, and `halted` is delayed by exactly the number of stalled cycles.
- **Random and reset mid-burst:** mode 10 from reset for 64 cycles -> stall pattern matches a reference LFSR model seeded with 16'hACE1. `rst` pulsed mid-burst -> pattern restarts identically.
